// File: rtl/multicycle_computer_memory_unit_pkg.sv
// Shared definitions for the multicycle computer memory unit: the load/run FSM encoding
// and the default parameter values.
package multicycle_computer_memory_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

  localparam int unsigned DefaultDepthWords = 64;
  // ARM "mov r0, r0": a harmless instruction for the controller to see before the first fetch.
  localparam logic [31:0] DefaultNopInstr   = 32'hE1A00000;

endpackage

// File: rtl/multicycle_computer_memory_array.sv
// Word-wide storage for the memory unit: synchronous write, asynchronous read, no reset.
module multicycle_computer_memory_array #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/multicycle_computer_memory_unit.sv
// Unified instruction/data memory for a multicycle core: loads a program through a
// valid/ready port, then serves fetches and loads/stores while holding the core in run.
module multicycle_computer_memory_unit
  import multicycle_computer_memory_unit_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
  parameter logic [31:0] NOP_INSTR   = DefaultNopInstr
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ADR,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic        IRWrite,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] DATA,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        run,
  output logic        ADR_FAULT
);

  localparam int unsigned    AddrW   = $clog2(DEPTH_WORDS);
  localparam logic [AddrW-1:0] LastIdx = AddrW'(DEPTH_WORDS - 1);

  state_e             state_q, state_d;
  logic [AddrW-1:0]   load_ptr_q, load_ptr_d;
  logic [31:0]        instr_q, data_q;
  logic               ready_q, run_q, fault_q;

  logic               load_fire;
  logic               store_fault;
  logic [AddrW-1:0]   word_idx;
  logic               mem_we;
  logic [AddrW-1:0]   mem_waddr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic               unused_adr;

  // Upper address bits are dropped so accesses wrap modulo the array size.
  assign word_idx   = ADR[AddrW+1:2];
  assign unused_adr = ^ADR[31:AddrW+2];
  assign load_fire  = load_valid & ready_q;

  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    mem_we      = 1'b0;
    mem_waddr   = word_idx;
    mem_wdata   = WD;
    store_fault = 1'b0;
    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        if (load_fire) begin
          mem_we    = 1'b1;
          mem_waddr = load_ptr_q;
          mem_wdata = load_data;
          if (load_last || (load_ptr_q == LastIdx)) begin
            state_d = StRun;
          end else begin
            load_ptr_d = load_ptr_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (MemWrite) begin
          if (ADR[1:0] == 2'b00) begin
            mem_we = 1'b1;
          end else begin
            store_fault = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      load_ptr_q <= '0;
      instr_q    <= NOP_INSTR;
      data_q     <= '0;
      ready_q    <= 1'b0;
      run_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      ready_q    <= (state_d == StLoad);
      run_q      <= (state_d == StRun);
      // Async read of the pre-write contents gives read-before-write on a same-edge store.
      if (state_q == StRun) begin
        data_q <= mem_rdata;
        if (IRWrite) begin
          instr_q <= mem_rdata;
        end
      end
      if (store_fault) begin
        fault_q <= 1'b1;
      end
    end
  end

  multicycle_computer_memory_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AddrW)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (word_idx),
    .rdata (mem_rdata)
  );

  assign INSTRUCTION = instr_q;
  assign DATA        = data_q;
  assign load_ready  = ready_q;
  assign run         = run_q;
  assign ADR_FAULT   = fault_q;

endmodule
